ntt_iter_engine: RTL and testbench

NTT_ITER_ENGINE -- requirements
Module: ntt_iter_engine

---
 rtl/ntt_iter_engine.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_ntt_iter_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_iter_engine.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_iter_engine
//  Purpose  : Iterative number-theoretic transform engine. Loads N coefficient
//             pairs, runs an in-place forward NTT (Cooley-Tukey), an inverse
//             NTT (Gentleman-Sande followed by N'^-1 scaling) or a pointwise
//             modular multiply, then streams the N results back out.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i        in   1         clock, all state updates on rising edge
//    rst_n_i      in   1         synchronous reset, active low
//    run_i        in   1         start request, honoured in IDLE only
//    mode_i       in   2         00 NTT, 01 INTT, 10 PWM, 11 reserved
//    in_valid_i   in   1         load beat valid
//    in_ready_o   out  1         load beat accepted (LOAD state only)
//    in_data_i    in   2W        {b, a} coefficient pair
//    tw_addr_o    out  STAGES+1  twiddle ROM address
//    tw_i         in   W         twiddle ROM data, one cycle after address
//    out_valid_o  out  1         result beat valid
//    out_ready_i  in   1         result beat accepted
//    out_data_o   out  W         result coefficient
//    busy_o       out  1         high whenever not IDLE
//    done_o       out  1         one-cycle pulse after the final result beat
// ============================================================================
module ntt_iter_engine #(
  parameter int N      = 256,
  parameter int W      = 12,
  parameter int Q      = 3329,
  parameter int STAGES = 7,
  parameter int NINV   = 3303
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              run_i,
  input  logic [1:0]        mode_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2*W-1:0]    in_data_i,
  output logic [STAGES:0]   tw_addr_o,
  input  logic [W-1:0]      tw_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [W-1:0]      out_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int LOGN = $clog2(N);
  localparam int CW   = LOGN + 1;                          // counts 0..N
  localparam int SW   = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int AW   = STAGES + 1;

  localparam logic [1:0] MODE_NTT  = 2'b00;
  localparam logic [1:0] MODE_INTT = 2'b01;
  localparam logic [1:0] MODE_PWM  = 2'b10;
  localparam logic [1:0] MODE_RSV  = 2'b11;

  localparam logic [CW-1:0]   CNT_LAST   = CW'(N - 1);
  localparam logic [CW-1:0]   CNT_END    = CW'(N);
  localparam logic [LOGN-1:0] BFLY_LAST  = LOGN'(N / 2 - 1);
  localparam logic [SW-1:0]   STAGE_LAST = SW'(STAGES - 1);

  localparam logic [W-1:0]   Q_W    = W'(Q);
  localparam logic [W:0]     Q_X    = (W + 1)'(Q);
  localparam logic [2*W-1:0] Q_P    = (2 * W)'(Q);
  localparam logic [W-1:0]   NINV_W = W'(NINV);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_SCALE   = 3'd3,
    ST_UNLOAD  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Modular arithmetic helpers. Operands are always canonical, so a single
  // conditional correction suffices for add and subtract.
  // --------------------------------------------------------------------------
  function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= Q_X) s = s - Q_X;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (x < y) d = d + Q_X;
    return d[W-1:0];
  endfunction

  function automatic logic [W-1:0] mul_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    p = p % Q_P;
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] red_mod(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = x % Q_W;
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [1:0]      mode_q;
  logic [CW-1:0]   cnt_q;     // load / PWM / scale / unload index
  logic [SW-1:0]   stage_q;   // current transform layer
  logic [LOGN-1:0] bfly_q;    // butterfly index within the layer, 0..N/2-1
  logic            phase_q;   // 0: twiddle address issue, 1: compute/write

  logic [W-1:0]    a_mem [N];
  logic [W-1:0]    b_mem [N];

  // --------------------------------------------------------------------------
  // Butterfly addressing. With len = 2^lg, butterfly number b splits into
  // group g = b >> lg and offset b mod len, so j = g*2*len + offset and the
  // partner is j + len (bit lg of j is always clear).
  // --------------------------------------------------------------------------
  int              lg;
  logic [LOGN-1:0] grp;
  logic [LOGN-1:0] half;
  logic [LOGN-1:0] bf_j;
  logic [LOGN-1:0] bf_jl;
  logic [LOGN-1:0] bf_k;
  logic [W-1:0]    op_x;
  logic [W-1:0]    op_y;
  logic [W-1:0]    bf_t;
  logic [W-1:0]    bf_lo;
  logic [W-1:0]    bf_hi;

  always_comb begin
    lg    = 0;
    grp   = '0;
    half  = '0;
    bf_j  = '0;
    bf_jl = '0;
    bf_k  = '0;
    op_x  = '0;
    op_y  = '0;
    bf_t  = '0;
    bf_lo = '0;
    bf_hi = '0;

    // Forward layers shrink len from N/2; inverse layers grow it up to N/2.
    if (mode_q == MODE_INTT) lg = LOGN - STAGES + int'(stage_q);
    else                     lg = LOGN - 1 - int'(stage_q);

    grp   = bfly_q >> lg;
    half  = LOGN'(1) << lg;
    bf_j  = (grp << (lg + 1)) | (bfly_q & (half - LOGN'(1)));
    bf_jl = bf_j | half;
    bf_k  = LOGN'(N >> (lg + 1)) + grp;

    op_x = a_mem[bf_j];
    op_y = a_mem[bf_jl];

    if (mode_q == MODE_INTT) begin
      bf_lo = add_mod(op_x, op_y);
      bf_hi = mul_mod(tw_i, sub_mod(op_x, op_y));
    end else begin
      bf_t  = mul_mod(tw_i, op_y);
      bf_lo = add_mod(op_x, bf_t);
      bf_hi = sub_mod(op_x, bf_t);
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // FSM next state and combinational outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    busy_o     = (state_q != ST_IDLE);
    tw_addr_o  = '0;

    case (state_q)
      ST_IDLE: begin
        if (run_i && (mode_i != MODE_RSV)) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i && (cnt_q == CNT_LAST)) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (mode_q == MODE_PWM) begin
          if (cnt_q == CNT_LAST) state_d = ST_UNLOAD;
        end else begin
          // Inverse twiddles live in the upper half of the ROM.
          tw_addr_o = AW'(bf_k) | ((mode_q == MODE_INTT) ? (AW'(1) << STAGES) : AW'(0));
          if (phase_q && (bfly_q == BFLY_LAST) && (stage_q == STAGE_LAST))
            state_d = (mode_q == MODE_INTT) ? ST_SCALE : ST_UNLOAD;
        end
      end
      ST_SCALE: begin
        if (cnt_q == CNT_LAST) state_d = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        if (out_valid_o && out_ready_i && (cnt_q == CNT_END)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Coefficient storage (not cleared by reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    case (state_q)
      ST_LOAD: begin
        if (in_valid_i) begin
          a_mem[cnt_q[LOGN-1:0]] <= red_mod(in_data_i[W-1:0]);
          b_mem[cnt_q[LOGN-1:0]] <= red_mod(in_data_i[2*W-1:W]);
        end
      end
      ST_COMPUTE: begin
        if (mode_q == MODE_PWM) begin
          a_mem[cnt_q[LOGN-1:0]] <= mul_mod(a_mem[cnt_q[LOGN-1:0]], b_mem[cnt_q[LOGN-1:0]]);
        end else if (phase_q) begin
          a_mem[bf_j]  <= bf_lo;
          a_mem[bf_jl] <= bf_hi;
        end
      end
      ST_SCALE: begin
        a_mem[cnt_q[LOGN-1:0]] <= mul_mod(a_mem[cnt_q[LOGN-1:0]], NINV_W);
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters, mode latch and registered output stream
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mode_q      <= MODE_NTT;
      cnt_q       <= '0;
      stage_q     <= '0;
      bfly_q      <= '0;
      phase_q     <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q       <= '0;
          stage_q     <= '0;
          bfly_q      <= '0;
          phase_q     <= 1'b0;
          out_valid_o <= 1'b0;
          if (run_i && (mode_i != MODE_RSV)) mode_q <= mode_i;
        end
        ST_LOAD: begin
          if (in_valid_i) cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
        ST_COMPUTE: begin
          if (mode_q == MODE_PWM) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
          end else begin
            phase_q <= ~phase_q;
            if (phase_q) begin
              if (bfly_q == BFLY_LAST) begin
                bfly_q  <= '0;
                stage_q <= (stage_q == STAGE_LAST) ? '0 : stage_q + SW'(1);
              end else begin
                bfly_q <= bfly_q + LOGN'(1);
              end
            end
          end
        end
        ST_SCALE: begin
          cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
        ST_UNLOAD: begin
          // The first cycle in UNLOAD only fetches A[0]; afterwards each
          // accepted beat is replaced by the next coefficient on the same edge.
          if (out_valid_o && out_ready_i && (cnt_q == CNT_END)) begin
            out_valid_o <= 1'b0;
            done_o      <= 1'b1;
          end else if (!out_valid_o || out_ready_i) begin
            if (cnt_q != CNT_END) begin
              out_data_o  <= a_mem[cnt_q[LOGN-1:0]];
              out_valid_o <= 1'b1;
              cnt_q       <= cnt_q + CW'(1);
            end else begin
              out_valid_o <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ntt_iter_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ntt_iter_engine
//  Purpose  : Directed, table-driven bench for ntt_iter_engine with a small
//             configuration (N=4, W=5, Q=17, STAGES=2) and hand-computed
//             expected results, plus reset and handshake corner sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ntt_iter_engine;

  localparam int N      = 4;
  localparam int W      = 5;
  localparam int Q      = 17;
  localparam int STAGES = 2;
  localparam int NINV   = 13;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2*W-1:0]    in_data = '0;
  logic [STAGES:0]   tw_addr;
  logic [W-1:0]      tw;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [W-1:0]      out_data;
  logic              busy;
  logic              done;

  ntt_iter_engine #(
    .N(N), .W(W), .Q(Q), .STAGES(STAGES), .NINV(NINV)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .run_i       (run),
    .mode_i      (mode),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .tw_addr_o   (tw_addr),
    .tw_i        (tw),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  // Twiddle ROM: forward table at 1..3, inverse table at 5..7.
  logic [W-1:0] rom [8];
  initial begin
    rom[0] = 5'd0;  rom[1] = 5'd4;  rom[2] = 5'd2;  rom[3] = 5'd8;
    rom[4] = 5'd0;  rom[5] = 5'd13; rom[6] = 5'd9;  rom[7] = 5'd15;
  end
  always @(posedge clk) tw <= rom[tw_addr];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  typedef struct packed {
    logic [1:0]      mode;
    logic [3:0][4:0] a;
    logic [3:0][4:0] b;
    logic [3:0][4:0] e;
    logic [7:0]      lat;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic [1:0] m,
                              input int a0, input int a1, input int a2, input int a3,
                              input int b0, input int b1, input int b2, input int b3,
                              input int e0, input int e1, input int e2, input int e3,
                              input int l);
    vec_t r;
    r.mode = m;
    r.a[0] = 5'(a0); r.a[1] = 5'(a1); r.a[2] = 5'(a2); r.a[3] = 5'(a3);
    r.b[0] = 5'(b0); r.b[1] = 5'(b1); r.b[2] = 5'(b2); r.b[3] = 5'(b3);
    r.e[0] = 5'(e0); r.e[1] = 5'(e1); r.e[2] = 5'(e2); r.e[3] = 5'(e3);
    r.lat  = 8'(l);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse run, then push the four coefficient pairs. Returns the cycle count
  // sampled just after the last load handshake edge.
  task automatic start_load(input vec_t v, input string tag, output int c0);
    int g;
    @(negedge clk); run = 1'b1; mode = v.mode;
    @(negedge clk); run = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = {v.b[i], v.a[i]};
      g = 0;
      while (!in_ready && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (g >= 20) check({tag, "_load_timeout"}, 1, 0);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    c0 = cyc;
  endtask

  task automatic run_vec(input vec_t v, input string tag, input int hold_beat,
                         input int hold_n, input bit pulse);
    int c0, lat, beat, held, d0, extra, g, tw0;
    d0 = done_cnt;
    start_load(v, tag, c0);
    tw0 = (v.mode == 2'b00) ? 1 : ((v.mode == 2'b01) ? 6 : 0);

    lat = -1;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) begin
        check({tag, "_tw_addr0"}, int'(tw_addr), tw0);
        check({tag, "_in_ready_busy"}, int'(in_ready), 0);
      end
      if (out_valid) begin
        lat = cyc - c0;
        break;
      end
      run  = pulse && (k % 4 == 2);
      mode = pulse ? 2'b01 : v.mode;
    end
    run = 1'b0;
    check({tag, "_latency"}, lat, int'(v.lat));

    beat = 0; held = 0; g = 0;
    while (beat < N && g < 60) begin
      if (out_valid) begin
        if (beat == hold_beat && held < hold_n) begin
          out_ready = 1'b0;
          check($sformatf("%s_hold%0d", tag, held), int'(out_data), int'(v.e[beat]));
          held++;
        end else begin
          out_ready = 1'b1;
          check($sformatf("%s_d%0d", tag, beat), int'(out_data), int'(v.e[beat]));
          beat++;
        end
      end else begin
        out_ready = 1'b1;
      end
      g++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (g >= 60) check({tag, "_unload_timeout"}, beat, N);

    extra = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    check({tag, "_extra_beats"}, extra, 0);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_busy_end"}, int'(busy), 0);
  endtask

  task automatic reset_and_check(input string tag);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check({tag, "_rst_busy"}, int'(busy), 0);
    check({tag, "_rst_in_ready"}, int'(in_ready), 0);
    check({tag, "_rst_out_valid"}, int'(out_valid), 0);
    check({tag, "_rst_out_data"}, int'(out_data), 0);
    check({tag, "_rst_done"}, int'(done), 0);
    check({tag, "_rst_tw_addr"}, int'(tw_addr), 0);
    rst_n = 1'b1;
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (out_valid || busy || in_ready || done) bad++;
    end
    check({tag, "_quiet"}, bad, 0);
  endtask

  initial begin
    int c0, g;

    vecs[0] = mk(2'b00,  1, 0, 0, 0,   0, 0, 0, 0,   1, 1, 1, 1,   9);
    vecs[1] = mk(2'b00,  0, 1, 0, 0,   0, 0, 0, 0,   2, 15, 8, 9,  9);
    vecs[2] = mk(2'b01,  2, 15, 8, 9,  0, 0, 0, 0,   0, 1, 0, 0,   13);
    vecs[3] = mk(2'b10,  3, 16, 0, 5,  6, 16, 9, 7,  1, 1, 0, 1,   5);
    vecs[4] = mk(2'b00,  18, 0, 0, 0,  0, 0, 0, 0,   1, 1, 1, 1,   9);
    vecs[5] = mk(2'b10,  31, 17, 16, 2, 1, 5, 16, 9, 14, 0, 1, 1,  5);
    vecs[6] = mk(2'b00,  0, 0, 1, 0,   0, 0, 0, 0,   4, 4, 13, 13, 9);
    vecs[7] = mk(2'b01,  4, 4, 13, 13, 0, 0, 0, 0,   0, 0, 1, 0,   13);

    repeat (2) @(negedge clk);
    check("init_busy", int'(busy), 0);
    check("init_in_ready", int'(in_ready), 0);
    check("init_out_valid", int'(out_valid), 0);
    check("init_out_data", int'(out_data), 0);
    check("init_done", int'(done), 0);
    check("init_tw_addr", int'(tw_addr), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i), (i == 1) ? 1 : -1, (i == 1) ? 3 : 0, 1'b0);
    end

    // Reset in the middle of COMPUTE: nothing of the aborted run may emerge.
    start_load(vecs[1], "rc", c0);
    repeat (3) @(negedge clk);
    reset_and_check("rc");
    watch_quiet("rc", 30);

    // Reserved mode must not start anything.
    @(negedge clk); run = 1'b1; mode = 2'b11;
    @(negedge clk); run = 1'b0; mode = 2'b00;
    watch_quiet("rsv", 4);

    // Fresh NTT after the abort, with stray run pulses while busy.
    run_vec(vecs[0], "post_rst", -1, 0, 1'b1);

    // Reset in the middle of UNLOAD after one beat has been taken.
    start_load(vecs[6], "ru", c0);
    g = 0;
    while (!out_valid && g < 60) begin
      @(negedge clk);
      g++;
    end
    check("ru_first_valid", int'(out_valid), 1);
    @(negedge clk);
    reset_and_check("ru");
    watch_quiet("ru", 20);

    run_vec(vecs[3], "recover", -1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
